// File: rtl/dr_load_pkg.sv
// ---------------------------------------------------------------------------
// dr_load_pkg
//
// Shared definitions for the DR load sequencer:
//   - FSM state encoding (IDLE, FETCH, DONE)
//   - load mode codes as presented on the Mode input
//   - DR function-select codes driven towards the data register
//   - helpers that map a latched mode to its function select and tell
//     byte loads apart from word loads
// ---------------------------------------------------------------------------
package dr_load_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Load modes
    localparam logic [1:0] MODE_SEXT = 2'b00;  // one byte, sign-extended
    localparam logic [1:0] MODE_ZEXT = 2'b01;  // one byte, zero-extended
    localparam logic [1:0] MODE_BE   = 2'b10;  // four bytes, big-endian
    localparam logic [1:0] MODE_LE   = 2'b11;  // four bytes, little-endian

    // DR function selects
    localparam logic [1:0] FS_SEXT = 2'b00;    // DR <= sign-extended byte
    localparam logic [1:0] FS_ZEXT = 2'b01;    // DR <= zero-extended byte
    localparam logic [1:0] FS_SHL  = 2'b10;    // DR <= {DR[23:0], byte}
    localparam logic [1:0] FS_SHR  = 2'b11;    // DR <= {byte, DR[31:8]}

    // Index of the final byte of a word load
    localparam logic [1:0] LAST_BYTE = 2'd3;

    // Each load mode drives exactly one DR operation for its whole transfer.
    function automatic logic [1:0] modeToFunSel(input logic [1:0] mode);
        logic [1:0] funSel;
        funSel = FS_SEXT;
        case (mode)
            MODE_SEXT: funSel = FS_SEXT;
            MODE_ZEXT: funSel = FS_ZEXT;
            MODE_BE:   funSel = FS_SHL;
            MODE_LE:   funSel = FS_SHR;
            default:   funSel = FS_SEXT;
        endcase
        return funSel;
    endfunction

    // Word modes occupy the upper half of the mode code space.
    function automatic logic isWordMode(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/dr_load_timer.sv
// ---------------------------------------------------------------------------
// dr_load_timer
//
// Counts consecutive FETCH cycles in which the memory has not acknowledged.
// The sequencer clears it whenever a new byte is requested and steps it on
// every unacknowledged cycle. expired_o is raised during the cycle in which
// the count has reached TIMEOUT-1, i.e. the TIMEOUT-th waiting cycle, so an
// abort taken on that edge happens after exactly TIMEOUT waiting cycles.
// TIMEOUT = 0 disables the timer completely.
//
// Ports:
//   clk_i      system clock
//   reset_i    synchronous active-high reset
//   clear_i    restart the count at zero (takes priority over inc_i)
//   inc_i      one more unacknowledged cycle
//   expired_o  current cycle is the last one allowed without an ack
// ---------------------------------------------------------------------------
module dr_load_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    // A zero-width counter is not legal, so keep at least one bit.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST_WAIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX   = '1;

    logic [CW-1:0] waitCnt_q;
    logic [CW-1:0] waitCnt_d;

    // Next count: saturate instead of wrapping so a disabled or stalled
    // timer never produces a spurious match.
    always_comb begin
        waitCnt_d = waitCnt_q;
        if (clear_i) begin
            waitCnt_d = '0;
        end else if (inc_i && (waitCnt_q != CNT_MAX)) begin
            waitCnt_d = waitCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            waitCnt_q <= '0;
        end else begin
            waitCnt_q <= waitCnt_d;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_noTimeout
            assign expired_o = 1'b0;
        end else begin : g_timeout
            assign expired_o = (waitCnt_q == LAST_WAIT);
        end
    endgenerate

endmodule

// File: rtl/dr_load_sequencer.sv
// ---------------------------------------------------------------------------
// dr_load_sequencer
//
// Sequences 32-bit data register (DR) loads from a byte-wide memory. A start
// request latches the mode and base address, then one byte (byte modes) or
// four consecutive bytes (word modes) are fetched over a req/ack handshake.
// The memory data bus feeds the DR byte input directly; this block only
// raises the DR enable on each acknowledged byte and holds the DR function
// select that matches the latched mode, so the DR assembles the result.
//
// Ports:
//   clk_i        system clock
//   reset_i      synchronous active-high reset
//   start_i      load request, honoured only in IDLE
//   mode_i       00 sext byte, 01 zext byte, 10 BE word, 11 LE word
//   baseAddr_i   address of the first byte
//   memAck_i     memory presents the byte for memAddr_o this cycle
//   memReq_o     registered fetch request
//   memAddr_o    registered byte address
//   drE_o        DR enable (acknowledged byte while fetching)
//   drFunSel_o   DR function select for the latched mode
//   busy_o       an operation is in progress
//   done_o       one-cycle pulse at the end of every operation
//   error_o      one-cycle pulse alongside done_o on a timeout abort
// ---------------------------------------------------------------------------
module dr_load_sequencer
    import dr_load_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [ADDR_WIDTH-1:0] baseAddr_i,
    input  logic                  memAck_i,
    output logic                  memReq_o,
    output logic [ADDR_WIDTH-1:0] memAddr_o,
    output logic                  drE_o,
    output logic [1:0]            drFunSel_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    state_e                state_q,   state_d;
    logic [1:0]            mode_q,    mode_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [1:0]            byteCnt_q, byteCnt_d;
    logic                  memReq_q,  memReq_d;
    logic                  abort_q,   abort_d;

    logic                  timerClear;
    logic                  timerInc;
    logic                  timerExpired;

    dr_load_timer #(
        .TIMEOUT   (TIMEOUT)
    ) u_timer (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (timerClear),
        .inc_i     (timerInc),
        .expired_o (timerExpired)
    );

    // Next-state logic. The DR captures a byte on every edge where the
    // memory acknowledges in FETCH; the FSM only decides whether another
    // byte follows. An ack in the same cycle as the timer expiring still
    // completes the transfer normally.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        addr_d     = addr_q;
        byteCnt_d  = byteCnt_q;
        memReq_d   = memReq_q;
        abort_d    = abort_q;
        timerClear = 1'b0;
        timerInc   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mode_d     = mode_i;
                    addr_d     = baseAddr_i;
                    byteCnt_d  = '0;
                    memReq_d   = 1'b1;
                    abort_d    = 1'b0;
                    timerClear = 1'b1;
                    state_d    = FETCH;
                end
            end

            FETCH: begin
                if (memAck_i) begin
                    timerClear = 1'b1;
                    if (!isWordMode(mode_q) || (byteCnt_q == LAST_BYTE)) begin
                        memReq_d = 1'b0;
                        state_d  = DONE;
                    end else begin
                        byteCnt_d = byteCnt_q + 2'd1;
                        addr_d    = addr_q + 1'b1;
                    end
                end else begin
                    timerInc = 1'b1;
                    if (timerExpired) begin
                        memReq_d = 1'b0;
                        abort_d  = 1'b1;
                        state_d  = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d  = IDLE;
                memReq_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            mode_q    <= MODE_SEXT;
            addr_q    <= '0;
            byteCnt_q <= '0;
            memReq_q  <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            addr_q    <= addr_d;
            byteCnt_q <= byteCnt_d;
            memReq_q  <= memReq_d;
            abort_q   <= abort_d;
        end
    end

    // The DR sees the same clock edge as the reset, so the enable must be
    // suppressed while reset is asserted to keep the DR untouched.
    assign drE_o      = memAck_i && (state_q == FETCH) && !reset_i;
    assign drFunSel_o = modeToFunSel(mode_q);
    assign memReq_o   = memReq_q;
    assign memAddr_o  = addr_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign error_o    = (state_q == DONE) && abort_q;

endmodule

// File: tb/tb_dr_load_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dr_load_sequencer
//
// Byte memory plus a behavioural DR are wrapped around the sequencer. Each
// load pushes its hand-computed final DR value, error flag and Done latency
// into a scoreboard, and the expected address sequence into a second queue;
// a negedge monitor checks them as the DUT presents addresses and Done.
// ---------------------------------------------------------------------------
module tb_dr_load_sequencer;
    import dr_load_pkg::*;

    localparam int AW = 16;
    localparam int TO = 15;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    mode;
    logic [AW-1:0] baseAddr;
    logic          memAck;
    logic          memReq;
    logic [AW-1:0] memAddr;
    logic          drE;
    logic [1:0]    drFunSel;
    logic          busy;
    logic          done;
    logic          error;

    typedef struct {
        logic [31:0] dr;
        logic        err;
        int          latency;
    } exp_t;

    logic [7:0]    mem [0:65535];
    logic [31:0]   drModel = 32'h0;
    exp_t          sbQ[$];
    logic [AW-1:0] addrQ[$];
    int            waitQ[$];

    int assertCount = 0;
    int failCount   = 0;
    int cycleCnt    = 0;
    int startCycle  = 0;
    int ackMode     = 0;

    dr_load_sequencer #(
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO)
    ) dut (
        .clk_i      (clock),
        .reset_i    (reset),
        .start_i    (start),
        .mode_i     (mode),
        .baseAddr_i (baseAddr),
        .memAck_i   (memAck),
        .memReq_o   (memReq),
        .memAddr_o  (memAddr),
        .drE_o      (drE),
        .drFunSel_o (drFunSel),
        .busy_o     (busy),
        .done_o     (done),
        .error_o    (error)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    // Cycle counter used to measure Done latency from the Start edge.
    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    // Behavioural DR: on each enabled edge, combine the byte on the memory
    // bus with the current DR value as the function select dictates.
    always @(posedge clock) begin
        if (drE) begin
            case (drFunSel)
                FS_SEXT: drModel <= {{24{mem[memAddr][7]}}, mem[memAddr]};
                FS_ZEXT: drModel <= {24'h0, mem[memAddr]};
                FS_SHL:  drModel <= {drModel[23:0], mem[memAddr]};
                default: drModel <= {mem[memAddr], drModel[31:8]};
            endcase
        end
    end

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Memory acknowledge driver. Mode 0 ties ack high, mode 1 never acks,
    // mode 2 inserts the number of wait cycles taken from waitQ before each
    // byte's ack.
    initial begin
        int waitLeft;
        waitLeft = -1;
        memAck   = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (ackMode == 0) begin
                memAck = 1'b1;
            end else if (ackMode == 1) begin
                memAck = 1'b0;
            end else if (!memReq) begin
                memAck   = 1'b0;
                waitLeft = -1;
            end else begin
                if (waitLeft < 0) waitLeft = (waitQ.size() > 0) ? waitQ.pop_front() : 0;
                if (waitLeft > 0) begin
                    memAck = 1'b0;
                    waitLeft--;
                end else begin
                    memAck   = 1'b1;
                    waitLeft = -1;
                end
            end
        end
    end

    // Monitor: verifies the address sequence (and its stability during
    // waits), DR enable staying low outside FETCH, Error only with Done, and
    // pops the scoreboard whenever Done is presented.
    always @(negedge clock) begin
        if (!reset) begin
            if (memReq) begin
                if (addrQ.size() == 0) begin
                    assertCount++;
                    failCount++;
                    $display("[TB] FAIL mem_addr: got 0x%04h, expected no request", memAddr);
                end else begin
                    checkOutput("mem_addr", 32'(memAddr), 32'(addrQ[0]));
                    if (drE) void'(addrQ.pop_front());
                end
            end
            if (!busy && memAck) checkOutput("dr_e_idle", 32'(drE), 32'd0);
            if (!done) checkOutput("error_without_done", 32'(error), 32'd0);
            if (done) begin
                if (sbQ.size() == 0) begin
                    assertCount++;
                    failCount++;
                    $display("[TB] FAIL done: got unexpected Done, expected none");
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    checkOutput("dr_value", drModel, e.dr);
                    checkOutput("error", 32'(error), 32'(e.err));
                    checkOutput("done_latency", 32'(cycleCnt - startCycle), 32'(e.latency));
                end
            end
        end
    end

    // Issues one load and waits (bounded) for it to finish. Optionally
    // pulses Start again while the sequencer is busy.
    task automatic applyStimulus(input logic [1:0] m, input logic [AW-1:0] base,
                                 input int ackSel, input logic [31:0] expDr,
                                 input logic expErr, input int expLat,
                                 input int nAddr, input bit pulseBusy);
        ackMode = ackSel;
        addrQ.delete();
        @(posedge clock);
        #1;
        start      = 1'b1;
        mode       = m;
        baseAddr   = base;
        startCycle = cycleCnt;
        sbQ.push_back('{expDr, expErr, expLat});
        for (int i = 0; i < nAddr; i++) addrQ.push_back(AW'(base + AW'(i)));
        @(posedge clock);
        #1;
        start    = 1'b0;
        mode     = ~m;
        baseAddr = ~base;
        if (pulseBusy) begin
            @(posedge clock);
            #1;
            start = 1'b1;
            @(posedge clock);
            #1;
            start = 1'b0;
        end
        for (int c = 0; c < 100 && busy; c++) begin
            @(posedge clock);
            #1;
        end
        if (busy) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL completion: got busy after 100 cycles, expected idle");
        end
        checkOutput("mem_req_after_op", 32'(memReq), 32'd0);
    endtask

    // Bounds the whole run in case something hangs despite the local limits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'h11;
        mem[16'h0011] = 8'h22;
        mem[16'h0012] = 8'h33;
        mem[16'h0013] = 8'h44;
        mem[16'h0020] = 8'h80;
        mem[16'hFFFE] = 8'hA1;
        mem[16'hFFFF] = 8'hB2;
        mem[16'h0000] = 8'hC3;
        mem[16'h0001] = 8'hD4;
        mem[16'h0030] = 8'h5A;

        reset    = 1'b1;
        start    = 1'b0;
        mode     = 2'b00;
        baseAddr = '0;
        ackMode  = 0;

        // Reset values, checked with ack high to confirm DR_E stays low.
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_mem_req", 32'(memReq), 32'd0);
        checkOutput("reset_mem_addr", 32'(memAddr), 32'd0);
        checkOutput("reset_fun_sel", 32'(drFunSel), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_error", 32'(error), 32'd0);
        checkOutput("reset_dr_e", 32'(drE), 32'd0);
        reset = 1'b0;

        // Reset during a word load after two bytes, ack still high.
        @(posedge clock);
        #1;
        start    = 1'b1;
        mode     = MODE_BE;
        baseAddr = 16'h0010;
        for (int i = 0; i < 4; i++) addrQ.push_back(AW'(16'h0010 + i));
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("dr_e_in_reset", 32'(drE), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("post_reset_mem_req", 32'(memReq), 32'd0);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);
        checkOutput("post_reset_mem_addr", 32'(memAddr), 32'd0);
        checkOutput("post_reset_done", 32'(done), 32'd0);
        checkOutput("post_reset_dr", drModel, 32'h0000_1122);

        // Word and byte loads with ack tied high.
        applyStimulus(MODE_BE,   16'h0010, 0, 32'h1122_3344, 1'b0, 5, 4, 1'b0);
        applyStimulus(MODE_LE,   16'h0010, 0, 32'h4433_2211, 1'b0, 5, 4, 1'b0);
        applyStimulus(MODE_SEXT, 16'h0020, 0, 32'hFFFF_FF80, 1'b0, 2, 1, 1'b0);
        applyStimulus(MODE_ZEXT, 16'h0020, 0, 32'h0000_0080, 1'b0, 2, 1, 1'b0);

        // Address wrap with wait states 2,0,3,1 and a Start pulse while busy.
        waitQ.push_back(2);
        waitQ.push_back(0);
        waitQ.push_back(3);
        waitQ.push_back(1);
        applyStimulus(MODE_BE, 16'hFFFE, 2, 32'hA1B2_C3D4, 1'b0, 11, 4, 1'b1);

        // No ack at all: abort after 15 waits, DR keeps its previous value.
        applyStimulus(MODE_BE, 16'h0030, 1, 32'hA1B2_C3D4, 1'b1, 16, 1, 1'b0);

        // Ack arriving in the 15th waiting-window cycle completes normally.
        waitQ.push_back(14);
        applyStimulus(MODE_SEXT, 16'h0020, 2, 32'hFFFF_FF80, 1'b0, 16, 1, 1'b0);

        repeat (3) @(posedge clock);
        #1;
        checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
